up_counter_ctrl: RTL and testbench
==================================

Name: up_counter_ctrl

Overview:
Sequencing controller for an N-bit up counter, turning the free-running binary counter into a programmable period timer. It supports start/stop/hold control, a programmable terminal value, one-shot or auto-reload operation, terminal-count pulses and a saturating period tally. It sits between control logic (FSM or register interface) and any datapath that needs a timed enable or event.

Parameters:
N, 8, width of count and limit
PW, 4, width of the period tally (periods)

Ports:
clk  input  1  clock, all state on rising edge
rstn  input  1  asynchronous active-low reset
start  input  1  request to begin counting; honoured only in IDLE
stop  input  1  abort; returns to IDLE from any state
hold  input  1  freeze count while high
auto_reload  input  1  1 = restart after terminal count, 0 = one-shot
limit  input  N  terminal value; captured on accepted start
count  output  N  current count value
busy  output  1  high in RUN or HOLD
tick  output  1  one-cycle pulse per completed period
done  output  1  one-cycle pulse when a one-shot run completes
periods  output  PW  completed periods since last start; saturates at all-ones

Behaviour:
- Clock is clk; reset is rstn, asynchronous and active-low. Reset is effective immediately and works mid-operation.
- Reset values:
  - state = IDLE
  - count = 0, limit_q = 0, periods = 0
  - busy = 0, tick = 0, done = 0
- All outputs are registered.
- States: IDLE, RUN, HOLD. Per-cycle priority: stop > hold > terminal/increment.
- IDLE:
  - start=1 and stop=0: limit_q <= limit, count <= 0, periods <= 0, go to RUN; busy=1 from the next edge.
  - Otherwise count holds its value.
- RUN:
  - stop=1: go to IDLE, count <= 0, busy <= 0, no tick/done.
  - hold=1: go to HOLD, count frozen.
  - count == limit_q (terminal):
    - count <= 0, tick <= 1, periods <= periods+1, saturating at 2^PW-1.
    - If auto_reload=1: stay in RUN.
    - If auto_reload=0: done <= 1, busy <= 0, go to IDLE.
  - Otherwise: count <= count+1. Increment never wraps, since terminal is reached first.
- auto_reload is sampled live at each terminal cycle, so clearing it ends an auto-reload run gracefully at the next terminal count.
- HOLD:
  - stop=1: go to IDLE as above.
  - hold=0: go to RUN with no increment that cycle (one-cycle bubble).
  - Otherwise count frozen.
- start is ignored while busy=1; limit changes are ignored until the next accepted start.
- tick/done are high for exactly one cycle, coincident with count already reading 0.
- Timing: start accepted at edge k, with count=0 after edge k. The terminal value L is reached after edge k+L. tick/done are visible after edge k+L+1. A one-shot run holds busy for L+1 cycles.
- limit=0: terminal every RUN cycle. Auto-reload gives tick every cycle; one-shot gives busy for 1 cycle, then done.
- stop and terminal in the same cycle: stop wins, no tick, no done, periods unchanged.
- start and stop in the same IDLE cycle: ignored.

Test Plan:
- One-shot: start, limit=5, auto_reload=0 -> count 0,1,2,3,4,5; busy 6 cycles; then tick=done=1 for one cycle with count=0, busy=0, periods=1.
- Auto-reload: limit=3, auto_reload=1 for 70 cycles -> tick every 4 cycles, done never; periods reaches 15 after the 15th tick and stays 15. Then clear auto_reload -> done at the next terminal, busy=0.
- Hold: limit=5, hold high for 3 cycles while count=2 -> count stays 2 for 4 cycles (3 hold + 1 bubble); tick arrives 4 cycles later than in the one-shot case.
- Stop: stop at count=4 with limit=5 -> count=0, busy=0, no done. Repeat with stop on the terminal cycle (count=5) -> no tick, no done, periods=0.
- Edge cases: limit=0 one-shot -> busy 1 cycle then done. start with limit=9 while busy -> ignored; limit_q unchanged, timing unchanged.
- Reset: rstn low mid-run at count=3 -> all outputs 0 immediately, asynchronous to clk. After release, start with limit=2 -> normal 3-cycle run with done.

Source files
------------

// File: rtl/up_counter_ctrl_if.sv
// Bundle of control and status signals between a sequencer (master) and
// the up_counter_ctrl period timer (slave).
//   start, stop, hold, auto_reload : run control from the master
//   limit                          : terminal value, captured on accepted start
//   count                          : current count value
//   busy                           : timer is running or held
//   tick                           : one-cycle pulse per completed period
//   done                           : one-cycle pulse when a one-shot run ends
//   periods                        : saturating tally of completed periods
interface up_counter_ctrl_if #(
  parameter int N  = 8,
  parameter int PW = 4
);
  logic          start;
  logic          stop;
  logic          hold;
  logic          auto_reload;
  logic [N-1:0]  limit;
  logic [N-1:0]  count;
  logic          busy;
  logic          tick;
  logic          done;
  logic [PW-1:0] periods;

  modport master (
    output start, stop, hold, auto_reload, limit,
    input  count, busy, tick, done, periods
  );

  modport slave (
    input  start, stop, hold, auto_reload, limit,
    output count, busy, tick, done, periods
  );
endinterface

// File: rtl/up_counter_ctrl.sv
// Programmable period timer built around an N-bit up counter.
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rstn : asynchronous active-low reset
//   bus  : up_counter_ctrl_if.slave (start/stop/hold/auto_reload/limit in,
//          count/busy/tick/done/periods out); every output is registered.
//
// state | meaning
// IDLE  | waiting for start; count holds its value
// RUN   | counting up from 0 to the captured limit
// HOLD  | count frozen; leaving HOLD costs one bubble cycle with no increment
module up_counter_ctrl #(
  parameter int N  = 8,
  parameter int PW = 4
) (
  input  logic            clk,
  input  logic            rstn,
  up_counter_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  count_q, count_nxt;
  logic [N-1:0]  limit_q, limit_nxt;
  logic [PW-1:0] periods_q, periods_nxt;
  logic          busy_q, busy_nxt;
  logic          tick_q, tick_nxt;
  logic          done_q, done_nxt;
  logic          terminal;

  assign terminal = (count_q == limit_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      count_q   <= '0;
      limit_q   <= '0;
      periods_q <= '0;
      busy_q    <= 1'b0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      count_q   <= count_nxt;
      limit_q   <= limit_nxt;
      periods_q <= periods_nxt;
      busy_q    <= busy_nxt;
      tick_q    <= tick_nxt;
      done_q    <= done_nxt;
    end
  end

  // Priority inside the active states is stop > hold > terminal/increment.
  always_comb begin
    state_nxt   = state;
    count_nxt   = count_q;
    limit_nxt   = limit_q;
    periods_nxt = periods_q;
    tick_nxt    = 1'b0;
    done_nxt    = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          limit_nxt   = bus.limit;
          count_nxt   = '0;
          periods_nxt = '0;
          state_nxt   = RUN;
        end
      end

      RUN: begin
        if (bus.stop) begin
          count_nxt = '0;
          state_nxt = IDLE;
        end else if (bus.hold) begin
          state_nxt = HOLD;
        end else if (terminal) begin
          count_nxt   = '0;
          tick_nxt    = 1'b1;
          periods_nxt = (periods_q == {PW{1'b1}}) ? periods_q : periods_q + 1'b1;
          // auto_reload is looked at only here, so clearing it mid-run
          // lets the current period finish before the run ends.
          if (!bus.auto_reload) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end else begin
          // Never wraps: the terminal compare catches count first.
          count_nxt = count_q + 1'b1;
        end
      end

      HOLD: begin
        if (bus.stop) begin
          count_nxt = '0;
          state_nxt = IDLE;
        end else if (!bus.hold) begin
          state_nxt = RUN;
        end
      end

      default: begin
        count_nxt = '0;
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  assign bus.count   = count_q;
  assign bus.busy    = busy_q;
  assign bus.tick    = tick_q;
  assign bus.done    = done_q;
  assign bus.periods = periods_q;

endmodule

// File: tb/tb_up_counter_ctrl.sv
module tb_up_counter_ctrl;

  logic clk;
  logic rstn;
  int   tests;
  int   fails;

  up_counter_ctrl_if #(.N(8), .PW(4)) bus ();

  up_counter_ctrl #(.N(8), .PW(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: timer described as "running / paused / idle" plus the
  // count and the period tally, updated by the behavioural rules directly.
  bit       m_running;
  bit       m_paused;
  int       m_count;
  int       m_lim;
  int       m_periods;
  bit       m_tick;
  bit       m_done;

  task automatic model_reset();
    m_running = 0; m_paused = 0; m_count = 0; m_lim = 0;
    m_periods = 0; m_tick = 0; m_done = 0;
  endtask

  task automatic model_edge(input bit s, input bit p, input bit h, input bit a, input int l);
    m_tick = 0;
    m_done = 0;
    if (!m_running) begin
      if (s && !p) begin
        m_running = 1; m_paused = 0; m_lim = l; m_count = 0; m_periods = 0;
      end
    end else if (p) begin
      m_running = 0; m_paused = 0; m_count = 0;
    end else if (m_paused) begin
      if (!h) m_paused = 0;
    end else if (h) begin
      m_paused = 1;
    end else if (m_count == m_lim) begin
      m_count   = 0;
      m_tick    = 1;
      m_periods = (m_periods + 1 > 15) ? 15 : m_periods + 1;
      if (!a) begin
        m_done    = 1;
        m_running = 0;
      end
    end else begin
      m_count = m_count + 1;
    end
  endtask

  task automatic check_all(input string tag);
    tests++;
    assert (bus.count === 8'(m_count)) else begin
      fails++; $error("FAIL %s count got %0d exp %0d", tag, bus.count, m_count);
    end
    tests++;
    assert (bus.busy === m_running) else begin
      fails++; $error("FAIL %s busy got %0b exp %0b", tag, bus.busy, m_running);
    end
    tests++;
    assert (bus.tick === m_tick) else begin
      fails++; $error("FAIL %s tick got %0b exp %0b", tag, bus.tick, m_tick);
    end
    tests++;
    assert (bus.done === m_done) else begin
      fails++; $error("FAIL %s done got %0b exp %0b", tag, bus.done, m_done);
    end
    tests++;
    assert (bus.periods === 4'(m_periods)) else begin
      fails++; $error("FAIL %s periods got %0d exp %0d", tag, bus.periods, m_periods);
    end
  endtask

  // Drive inputs away from the edge, take one rising edge, update the model,
  // then compare one time unit later.
  task automatic step(input bit s, input bit p, input bit h, input bit a,
                      input int l, input string tag);
    bus.start = s; bus.stop = p; bus.hold = h; bus.auto_reload = a;
    bus.limit = 8'(l);
    @(posedge clk);
    if (rstn) model_edge(s, p, h, a, l);
    #1;
    check_all(tag);
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++; $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  initial begin
    int busy_cnt, done_cnt, tick_cnt, tick_at, n;
    bit seen;
    tests = 0;
    fails = 0;
    bus.start = 0; bus.stop = 0; bus.hold = 0; bus.auto_reload = 0; bus.limit = '0;
    model_reset();
    rstn = 1'b0;
    #12;
    check_all("reset");
    rstn = 1'b1;
    step(0, 0, 0, 0, 0, "idle");

    // One-shot, limit 5
    busy_cnt = 0; done_cnt = 0; tick_cnt = 0;
    step(1, 0, 0, 0, 5, "os_start");
    if (bus.busy) busy_cnt++;
    for (int i = 0; i < 9; i++) begin
      step(0, 0, 0, 0, 5, "os_run");
      if (bus.busy) busy_cnt++;
      if (bus.done) done_cnt++;
      if (bus.tick) tick_cnt++;
    end
    check_int("os_busy_cycles", busy_cnt, 6);
    check_int("os_done_pulses", done_cnt, 1);
    check_int("os_tick_pulses", tick_cnt, 1);
    check_int("os_periods", int'(bus.periods), 1);

    // Auto-reload, limit 3, 70 cycles, then clear auto_reload
    tick_cnt = 0; done_cnt = 0;
    step(1, 0, 0, 1, 3, "ar_start");
    for (int i = 1; i <= 70; i++) begin
      step(0, 0, 0, 1, 3, "ar_run");
      if (bus.tick) tick_cnt++;
      if (bus.done) done_cnt++;
    end
    check_int("ar_ticks", tick_cnt, 17);
    check_int("ar_no_done", done_cnt, 0);
    check_int("ar_periods_sat", int'(bus.periods), 15);
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      step(0, 0, 0, 0, 3, "ar_clear");
      if (bus.done) seen = 1;
    end
    check_int("ar_end_done", int'(seen), 1);
    check_int("ar_end_busy", int'(bus.busy), 0);

    // Hold for 3 cycles at count 2, limit 5
    tick_at = -1;
    step(1, 0, 0, 0, 5, "hold_start");
    step(0, 0, 0, 0, 5, "hold_pre");
    step(0, 0, 0, 0, 5, "hold_pre");
    check_int("hold_count2", int'(bus.count), 2);
    for (int i = 3; i <= 5; i++) step(0, 0, 1, 0, 5, "hold_on");
    for (int i = 6; i <= 14 && tick_at < 0; i++) begin
      step(0, 0, 0, 0, 5, "hold_off");
      if (bus.tick) tick_at = i;
    end
    check_int("hold_tick_step", tick_at, 10);

    // Stop at count 4, then stop on the terminal cycle
    step(1, 0, 0, 0, 5, "stop_start");
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 5, "stop_run");
    step(0, 1, 0, 0, 5, "stop_at4");
    step(1, 0, 0, 0, 5, "stopt_start");
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 5, "stopt_run");
    step(0, 1, 0, 0, 5, "stop_term");
    check_int("stop_term_periods", int'(bus.periods), 0);

    // limit 0 one-shot, and start+stop together in IDLE
    step(1, 1, 0, 0, 4, "start_stop_idle");
    step(1, 0, 0, 0, 0, "l0_start");
    step(0, 0, 0, 0, 0, "l0_done");
    step(0, 0, 0, 0, 0, "l0_after");

    // Restart attempt with limit 9 while busy is ignored
    step(1, 0, 0, 0, 2, "busy_start");
    step(1, 0, 0, 0, 9, "busy_restart");
    step(1, 0, 0, 0, 9, "busy_restart");
    step(0, 0, 0, 0, 9, "busy_done");
    check_int("busy_restart_done", int'(bus.done), 1);

    // Asynchronous reset mid-run at count 3
    step(1, 0, 0, 1, 6, "rst_start");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 6, "rst_run");
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    check_all("async_reset");
    #3;
    rstn = 1'b1;
    step(1, 0, 0, 0, 2, "post_rst_start");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 2, "post_rst_run");

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      n = int'($urandom_range(0, 99));
      step(n < 25, n >= 96, ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 7)), "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout tb did not finish");
    $fatal(1, "timeout");
  end

endmodule
